// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared definitions for the CSR unit: CSR address map,
//               Zicsr funct3 encodings and the 2-bit operation kind.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // CSR address map
    localparam logic [11:0] TOHOST   = 12'h51E;
    localparam logic [11:0] CYCLE    = 12'hC00;
    localparam logic [11:0] CYCLEH   = 12'hC80;
    localparam logic [11:0] INSTRET  = 12'hC02;
    localparam logic [11:0] INSTRETH = 12'hC82;

    // Zicsr funct3 encodings
    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    // Operation kind, taken from funct3[1:0]
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free-running counter with count enable and
//               synchronous reset to CNT_INIT. Wraps 2^64-1 -> 0.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               en_i         - increment on this edge
//               count_o      - current count
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 #(
    parameter logic [63:0] CNT_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Single 64-bit add so the low-to-high carry lands on the same edge.
    assign cnt_d = en_i ? (cnt_q + 64'd1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : Execute-stage CSR unit. Implements the Zicsr instructions,
//               owns the tohost register and, optionally, the read-only
//               64-bit cycle/instret counters.
// Config      : CSR_COUNTERS_EN - when defined, cycle/instret counters and
//               their four addresses exist; otherwise those addresses are
//               unmapped.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               csr_valid, stall     - op qualifier and pipeline freeze
//               csr_funct3/addr      - Zicsr funct3 and CSR address
//               csr_rs1_idx/_data    - rs1 index (zimm) and forwarded value
//               instr_retire         - retire pulse for instret
//               csr_rdata(_valid)    - old CSR value for rd, one cycle later
//               csr_illegal          - illegal-access pulse
//               tohost               - current tohost value
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E,
    parameter logic [63:0] CNT_INIT    = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic            stall,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      csr_rs1_idx,
    input  logic [XLEN-1:0] csr_rs1_data,
    input  logic            instr_retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_rdata_valid,
    output logic            csr_illegal,
    output logic [XLEN-1:0] tohost
);

    logic [XLEN-1:0] tohost_q, tohost_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rdata_valid_q;
    logic            illegal_q;

    csr_op_e         w_op;
    logic            w_accept;
    logic            w_wr_intent;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_mapped;
    logic            w_ro;
    logic            w_is_tohost;
    logic            w_illegal;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_cycle;
    logic [63:0] w_instret;

    csr_counter64 #(.CNT_INIT(CNT_INIT)) u_cycle (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .count_o (w_cycle)
    );

    csr_counter64 #(.CNT_INIT(CNT_INIT)) u_instret (
        .clk     (clk),
        .rst     (rst),
        .en_i    (instr_retire),
        .count_o (w_instret)
    );
`else
    // Counters are absent; keep the retire input and init value consumed.
    logic w_unused;
    assign w_unused = ^{instr_retire, CNT_INIT};
`endif

    // funct3 000/100 have op kind 00 and are never accepted.
    assign w_op        = csr_op_e'(csr_funct3[1:0]);
    assign w_accept    = csr_valid && !stall && (w_op != OP_NONE);
    assign w_src       = csr_funct3[2] ? XLEN'(csr_rs1_idx) : csr_rs1_data;
    // Set/clear forms write only when the rs1 index (or zimm) is nonzero,
    // independent of the register value.
    assign w_wr_intent = (w_op == OP_RW) || (csr_rs1_idx != 5'd0);
    assign w_is_tohost = (csr_addr == TOHOST_ADDR);

    // Address decode: old value and access attributes.
    always_comb begin
        w_old    = '0;
        w_mapped = 1'b0;
        w_ro     = 1'b0;
        if (w_is_tohost) begin
            w_old    = tohost_q;
            w_mapped = 1'b1;
        end
`ifdef CSR_COUNTERS_EN
        else begin
            case (csr_addr)
                CYCLE: begin
                    w_old = XLEN'(w_cycle[31:0]);   w_mapped = 1'b1; w_ro = 1'b1;
                end
                CYCLEH: begin
                    w_old = XLEN'(w_cycle[63:32]);  w_mapped = 1'b1; w_ro = 1'b1;
                end
                INSTRET: begin
                    w_old = XLEN'(w_instret[31:0]); w_mapped = 1'b1; w_ro = 1'b1;
                end
                INSTRETH: begin
                    w_old = XLEN'(w_instret[63:32]); w_mapped = 1'b1; w_ro = 1'b1;
                end
                default: ;
            endcase
        end
`endif
    end

    always_comb begin
        w_new = w_old;
        case (w_op)
            OP_RW:   w_new = w_src;
            OP_RS:   w_new = w_old | w_src;
            OP_RC:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    assign w_illegal = !w_mapped || (w_ro && w_wr_intent);

    // tohost is the only writable CSR, so no illegal qualifier is needed.
    assign tohost_d = (w_accept && w_is_tohost && w_wr_intent) ? w_new : tohost_q;
    // w_old is already zero for unmapped addresses.
    assign rdata_d  = w_accept ? w_old : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            tohost_q      <= tohost_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= w_accept;
            illegal_q     <= w_accept && w_illegal;
        end
    end

    assign tohost          = tohost_q;
    assign csr_rdata       = rdata_q;
    assign csr_rdata_valid = rdata_valid_q;
    assign csr_illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Directed self-checking bench for csr_unit. A second instance
//               with a near-wrap counter init exercises the 32-bit carry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk;
    logic        rst;
    logic        csr_valid;
    logic        stall;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_rs1_data;
    logic        instr_retire;

    logic [31:0] csr_rdata,  csr_rdata2;
    logic        rvalid,     rvalid2;
    logic        illegal,    illegal2;
    logic [31:0] tohost,     tohost2;

    int n_vec = 0;
    int n_err = 0;

    csr_unit #(.XLEN(32), .TOHOST_ADDR(12'h51E), .CNT_INIT(64'h0)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .csr_valid       (csr_valid),
        .stall           (stall),
        .csr_funct3      (csr_funct3),
        .csr_addr        (csr_addr),
        .csr_rs1_idx     (csr_rs1_idx),
        .csr_rs1_data    (csr_rs1_data),
        .instr_retire    (instr_retire),
        .csr_rdata       (csr_rdata),
        .csr_rdata_valid (rvalid),
        .csr_illegal     (illegal),
        .tohost          (tohost)
    );

    csr_unit #(.XLEN(32), .TOHOST_ADDR(12'h51E), .CNT_INIT(64'hFFFF_FFF0)) u_dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .csr_valid       (csr_valid),
        .stall           (stall),
        .csr_funct3      (csr_funct3),
        .csr_addr        (csr_addr),
        .csr_rs1_idx     (csr_rs1_idx),
        .csr_rs1_data    (csr_rs1_data),
        .instr_retire    (instr_retire),
        .csr_rdata       (csr_rdata2),
        .csr_rdata_valid (rvalid2),
        .csr_illegal     (illegal2),
        .tohost          (tohost2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op and step past the accepting edge.
    task automatic op(input logic [2:0] f3, input logic [11:0] a,
                      input logic [4:0] idx, input logic [31:0] d);
        csr_valid    = 1'b1;
        csr_funct3   = f3;
        csr_addr     = a;
        csr_rs1_idx  = idx;
        csr_rs1_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; csr_valid = 1'b0; stall = 1'b0; csr_funct3 = 3'b000;
        csr_addr = 12'h0; csr_rs1_idx = 5'd0; csr_rs1_data = 32'h0;
        instr_retire = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tohost",  tohost,    0);
        chk("rst_rdata",   csr_rdata, 0);
        chk("rst_rvalid",  rvalid,    0);
        chk("rst_illegal", illegal,   0);
        rst = 1'b0;

        // csrrwi tohost, 1
        op(CSRRWI, TOHOST, 5'd1, 32'h0);
        chk("rwi_tohost",  tohost,    32'h1);
        chk("rwi_rdata",   csr_rdata, 32'h0);
        chk("rwi_rvalid",  rvalid,    1);
        chk("rwi_illegal", illegal,   0);

        // Back-to-back RW / RS / RC
        op(CSRRW, TOHOST, 5'd5, 32'h6);
        chk("rw_tohost", tohost,    32'h6);
        chk("rw_fail3",  tohost[31:1], 3);
        chk("rw_rdata",  csr_rdata, 32'h1);
        op(CSRRS, TOHOST, 5'd5, 32'h10);
        chk("rs_tohost", tohost,    32'h16);
        chk("rs_rdata",  csr_rdata, 32'h6);
        op(CSRRC, TOHOST, 5'd5, 32'h2);
        chk("rc_tohost", tohost,    32'h14);
        chk("rc_rdata",  csr_rdata, 32'h16);

        // RS with rs1=x0 but nonzero data: read only
        op(CSRRS, TOHOST, 5'd0, 32'hFF);
        chk("rsx0_tohost",  tohost,    32'h14);
        chk("rsx0_rdata",   csr_rdata, 32'h14);
        chk("rsx0_illegal", illegal,   0);

        // Immediate set/clear
        op(CSRRSI, TOHOST, 5'd1, 32'hFFFF_FFFF);
        chk("rsi_tohost", tohost,    32'h15);
        op(CSRRCI, TOHOST, 5'd4, 32'h0);
        chk("rci_tohost", tohost,    32'h11);
        chk("rci_rdata",  csr_rdata, 32'h15);

        idle();
        chk("idle_rvalid", rvalid,    0);
        chk("idle_hold",   csr_rdata, 32'h15);

        // funct3=000 is ignored
        op(3'b000, TOHOST, 5'd3, 32'h0);
        chk("f3z_rvalid",  rvalid,  0);
        chk("f3z_illegal", illegal, 0);
        chk("f3z_tohost",  tohost,  32'h11);

        // Unmapped address
        op(CSRRS, 12'h123, 5'd0, 32'h0);
        chk("unmap_rdata",   csr_rdata, 0);
        chk("unmap_illegal", illegal,   1);
        chk("unmap_rvalid",  rvalid,    1);
        idle();
        chk("unmap_pulse", illegal, 0);

        // Stall holds off the op for 3 cycles
        csr_valid = 1'b1; stall = 1'b1;
        csr_funct3 = CSRRW; csr_addr = TOHOST; csr_rs1_idx = 5'd1; csr_rs1_data = 32'h9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rvalid", rvalid, 0);
            chk("stall_tohost", tohost, 32'h11);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("unstall_tohost", tohost,    32'h9);
        chk("unstall_rvalid", rvalid,    1);
        chk("unstall_rdata",  csr_rdata, 32'h11);
        idle();
        chk("unstall_once", rvalid, 0);
        chk("unstall_keep", tohost, 32'h9);

        // Reset with an op pending
        op(CSRRWI, TOHOST, 5'd5, 32'h0);
        chk("pre_rst_tohost", tohost, 32'h5);
        csr_valid = 1'b1; csr_funct3 = CSRRWI; csr_rs1_idx = 5'd7; rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tohost", tohost,    0);
        chk("midrst_rvalid", rvalid,    0);
        chk("midrst_rdata",  csr_rdata, 0);
        csr_valid = 1'b0;
        rst = 1'b0;

`ifdef CSR_COUNTERS_EN
        // Counters from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        op(CSRRS, CYCLE, 5'd0, 32'hFFFF);
        chk("cycle_rdata",   csr_rdata,  10);
        chk("cycle_illegal", illegal,    0);
        chk("cycle_wrap_lo", csr_rdata2, 32'hFFFF_FFFA);
        op(CSRRS, CYCLEH, 5'd0, 32'h0);
        chk("cycleh_rdata", csr_rdata, 0);
        op(CSRRC, INSTRETH, 5'd0, 32'h0);
        chk("instreth_rdata", csr_rdata, 0);
        csr_valid = 1'b0;
        instr_retire = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        instr_retire = 1'b0;
        op(CSRRS, INSTRET, 5'd0, 32'h0);
        chk("instret_rdata", csr_rdata, 5);

        // Write to read-only counter
        op(CSRRW, CYCLE, 5'd3, 32'hABCD);
        chk("ro_wr_illegal", illegal,   1);
        chk("ro_wr_rdata",   csr_rdata, 19);
        op(CSRRS, CYCLE, 5'd0, 32'h0);
        chk("ro_wr_count", csr_rdata, 20);
        chk("ro_wr_clear", illegal,   0);

        // Carry from low to high word on the near-wrap instance
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        op(CSRRS, CYCLE, 5'd0, 32'h0);
        chk("carry_lo",     csr_rdata2, 0);
        chk("carry_lo_ill", illegal2,   0);
        op(CSRRS, CYCLEH, 5'd0, 32'h0);
        chk("carry_hi",     csr_rdata2, 1);
`else
        // Counter addresses are unmapped when counters are absent
        op(CSRRS, CYCLE, 5'd0, 32'h0);
        chk("nocnt_cycle_ill",   illegal,   1);
        chk("nocnt_cycle_rdata", csr_rdata, 0);
        op(CSRRS, CYCLEH, 5'd0, 32'h0);
        chk("nocnt_cycleh_ill", illegal, 1);
        op(CSRRS, INSTRET, 5'd0, 32'h0);
        chk("nocnt_instret_ill", illegal, 1);
        op(CSRRS, INSTRETH, 5'd0, 32'h0);
        chk("nocnt_instreth_ill", illegal, 1);
        chk("nocnt_tohost",       tohost,  0);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
